// File: rtl/pipe_pkg.sv
// Shared pipeline hazard types and constants.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned SB_DEPTH   = 3;

  localparam logic [1:0] STALL_NONE = 2'b00;
  localparam logic [1:0] STALL_ALL  = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker (EX, MEM, WB) with source match.
// RF_BYPASS_EN: register file writes early, so WB is not checked.
module hazard_scoreboard
  import pipe_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ins_valid_i,
  input  logic [REG_ADDR_W-1:0] ins_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  output logic                  rs1_hit_c,
  output logic                  rs2_hit_c
);

`ifdef RF_BYPASS_EN
  localparam logic [SB_DEPTH-1:0] CHK_MASK = 3'b011;
`else
  localparam logic [SB_DEPTH-1:0] CHK_MASK = 3'b111;
`endif

  sb_entry_t           sb_q [SB_DEPTH];
  sb_entry_t           sb_d [SB_DEPTH];
  logic [SB_DEPTH-1:0] rs1_m;
  logic [SB_DEPTH-1:0] rs2_m;

  // EX -> MEM -> WB shift
  always_comb begin
    sb_d[0] = {ins_valid_i, ins_rd_i};
    sb_d[1] = sb_q[0];
    sb_d[2] = sb_q[1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sb_q <= '{default: '0};
    end else begin
      sb_q <= sb_d;
    end
  end

  for (genvar g = 0; g < SB_DEPTH; g++) begin : g_match
    assign rs1_m[g] = sb_q[g].valid && (sb_q[g].rd == rs1_i);
    assign rs2_m[g] = sb_q[g].valid && (sb_q[g].rd == rs2_i);
  end

  always_comb begin
    rs1_hit_c = |(rs1_m & CHK_MASK);
    rs2_hit_c = |(rs2_m & CHK_MASK);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the non-forwarding 5-stage pipeline.
// RF_BYPASS_EN shortens the checked window to EX and MEM.
module hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic                  id_rs1_used_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_rd_we_i,
  input  logic                  id_valid_i,
  input  logic                  ex_br_taken_i,
  output logic [1:0]            stall_o,
  output logic                  flush_ifid_o,
  output logic                  flush_idex_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  import pipe_pkg::STALL_NONE;
  import pipe_pkg::STALL_ALL;

  logic             rs1_hit_c;
  logic             rs2_hit_c;
  logic             hazard_c;
  logic             ins_valid_c;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  hazard_scoreboard u_sb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ins_valid_i (ins_valid_c),
    .ins_rd_i    (id_rd_i),
    .rs1_i       (id_rs1_i),
    .rs2_i       (id_rs2_i),
    .rs1_hit_c   (rs1_hit_c),
    .rs2_hit_c   (rs2_hit_c)
  );

  // x0 never creates a dependency, as source or as destination
  always_comb begin
    hazard_c    = id_valid_i &&
                  ((id_rs1_used_i && (id_rs1_i != '0) && rs1_hit_c) ||
                   (id_rs2_used_i && (id_rs2_i != '0) && rs2_hit_c));
    ins_valid_c = id_valid_i && id_rd_we_i && (id_rd_i != '0) &&
                  !hazard_c && !ex_br_taken_i;
  end

  // Branch wins: the PC ignores its select while stalled
  always_comb begin
    stall_o      = STALL_NONE;
    flush_ifid_o = 1'b0;
    flush_idex_o = 1'b0;
    if (!rst_i) begin
      if (ex_br_taken_i) begin
        flush_ifid_o = 1'b1;
        flush_idex_o = 1'b1;
      end else if (hazard_c) begin
        stall_o      = STALL_ALL;
        flush_idex_o = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall_o != STALL_NONE) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl (4-bit stall counter instance).
module tb_hazard_ctrl;

`ifdef RF_BYPASS_EN
  localparam int S1 = 2;
  localparam int S2 = 1;
  localparam int S3 = 0;
`else
  localparam int S1 = 3;
  localparam int S2 = 2;
  localparam int S3 = 1;
`endif

  typedef struct {
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       v;
    logic       br;
    logic [1:0] stall;
    logic       fi;
    logic       fe;
    logic [3:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, we, v, br;
  logic [1:0] stall;
  logic       fi, fe;
  logic [3:0] cnt;

  vec_t       vecs[$];
  logic [3:0] cnt_run;
  int         checks;
  int         failures;

  hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_rs1_i      (rs1),
    .id_rs1_used_i (u1),
    .id_rs2_i      (rs2),
    .id_rs2_used_i (u2),
    .id_rd_i       (rd),
    .id_rd_we_i    (we),
    .id_valid_i    (v),
    .ex_br_taken_i (br),
    .stall_o       (stall),
    .flush_ifid_o  (fi),
    .flush_idex_o  (fe),
    .stall_cnt_o   (cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected counter value is the saturating count of earlier stall rows
  task automatic add(input int r1, input int a1, input int r2, input int a2,
                     input int d, input int w, input int vv, input int b,
                     input int st, input int f_i, input int f_e);
    vec_t x;
    x.rs1 = 5'(r1); x.u1 = 1'(a1); x.rs2 = 5'(r2); x.u2 = 1'(a2);
    x.rd = 5'(d); x.we = 1'(w); x.v = 1'(vv); x.br = 1'(b);
    x.stall = 2'(st); x.fi = 1'(f_i); x.fe = 1'(f_e); x.cnt = cnt_run;
    if ((st != 0) && (cnt_run != 4'hF)) cnt_run = cnt_run + 4'd1;
    vecs.push_back(x);
  endtask

  task automatic ins(input int r1, input int a1, input int r2, input int a2,
                     input int d, input int w);
    add(r1, a1, r2, a2, d, w, 1, 0, 0, 0, 0);
  endtask

  task automatic stl(input int r1, input int a1, input int r2, input int a2,
                     input int d, input int w, input int n);
    for (int k = 0; k < n; k++) add(r1, a1, r2, a2, d, w, 1, 0, 3, 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic apply_all(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rs1 = vecs[i].rs1; u1 = vecs[i].u1; rs2 = vecs[i].rs2; u2 = vecs[i].u2;
      rd = vecs[i].rd; we = vecs[i].we; v = vecs[i].v; br = vecs[i].br;
      #1;
      chk($sformatf("%s%0d_stall", tag, i), 32'(stall), 32'(vecs[i].stall));
      chk($sformatf("%s%0d_flush_ifid", tag, i), 32'(fi), 32'(vecs[i].fi));
      chk($sformatf("%s%0d_flush_idex", tag, i), 32'(fe), 32'(vecs[i].fe));
      chk($sformatf("%s%0d_cnt", tag, i), 32'(cnt), 32'(vecs[i].cnt));
    end
    vecs.delete();
  endtask

  initial begin
    checks = 0; failures = 0; cnt_run = 4'd0;
    rst = 1'b1;
    rs1 = '0; rs2 = '0; rd = '0; u1 = 1'b0; u2 = 1'b0; we = 1'b0; v = 1'b0;
    br = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_flush_ifid", 32'(fi), 32'd0);
    chk("reset_flush_idex", 32'(fe), 32'd0);
    chk("reset_cnt", 32'(cnt), 32'd0);
    br = 1'b0;
    @(negedge clk); rst = 1'b0;

    // back-to-back: addi x5,x0,1 ; add x6,x5,x5
    ins(0, 1, 0, 0, 5, 1);
    stl(5, 1, 5, 1, 6, 1, S1);
    ins(5, 1, 5, 1, 6, 1);
    drain();
    // x0 producer and unused-source cases
    ins(0, 1, 0, 0, 0, 1);
    ins(0, 1, 0, 1, 0, 0);
    ins(1, 1, 0, 0, 10, 1);
    ins(0, 1, 10, 0, 0, 0);
    ins(11, 1, 10, 0, 0, 0);
    drain();
    // distance 2: addi x7 ; independent ; sub x8,x7,x1
    ins(0, 1, 0, 0, 7, 1);
    ins(1, 1, 0, 0, 12, 1);
    stl(7, 1, 1, 1, 8, 1, S2);
    ins(7, 1, 1, 1, 8, 1);
    drain();
    // distance 3 and distance 4
    ins(0, 1, 0, 0, 13, 1);
    ins(1, 1, 0, 0, 20, 1);
    ins(1, 1, 0, 0, 21, 1);
    stl(0, 0, 13, 1, 0, 0, S3);
    ins(0, 0, 13, 1, 0, 0);
    ins(0, 1, 0, 0, 14, 1);
    ins(1, 1, 0, 0, 22, 1);
    ins(1, 1, 0, 0, 23, 1);
    ins(1, 1, 0, 0, 24, 1);
    ins(14, 1, 0, 0, 0, 0);
    drain();
    // branch beats a pending hazard; squashed rd x9 is not tracked
    ins(0, 1, 0, 0, 5, 1);
    add(5, 1, 0, 0, 9, 1, 1, 1, 0, 1, 1);
    ins(9, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    drain();
    // bubble in ID never stalls
    ins(0, 1, 0, 0, 15, 1);
    add(15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stl(15, 1, 0, 0, 0, 0, S2);
    ins(15, 1, 0, 0, 0, 0);
    drain();
    apply_all("t");

    // async reset in the second cycle of a back-to-back stall
    ins(0, 1, 0, 0, 5, 1);
    stl(5, 1, 5, 1, 6, 1, 2);
    apply_all("r");
    #1; rst = 1'b1; br = 1'b1;
    #1;
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_flush_ifid", 32'(fi), 32'd0);
    chk("midrst_flush_idex", 32'(fe), 32'd0);
    chk("midrst_cnt", 32'(cnt), 32'd0);
    @(negedge clk); rst = 1'b0; br = 1'b0;
    #1;
    chk("postrst_stall", 32'(stall), 32'd0);
    chk("postrst_cnt", 32'(cnt), 32'd0);

    // dependent chain long enough to saturate the 4-bit counter
    cnt_run = 4'd0;
    drain();
    ins(0, 1, 0, 0, 1, 1);
    for (int k = 1; k < 10; k++) begin
      stl(k, 1, 0, 0, k + 1, 1, S1);
      ins(k, 1, 0, 0, k + 1, 1);
    end
    stl(10, 1, 10, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_all("s");
    chk("sat_cnt", 32'(cnt), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Stall/flush controller for the non-forwarding 5-stage pipeline.
- Drives the PC's 2-bit stall input and the IF/ID and ID/EX flush controls.
- Tracks in-flight destination registers with an internal 3-entry scoreboard (EX, MEM, WB) and stalls ID until every RAW source is retired.
- Also squashes wrong-path instructions when EX resolves a taken branch/jump.

Parameters:
REG_ADDR_W, 5, register index width
CNT_W, 32, stall performance counter width

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-high reset
id_rs1_i  input  REG_ADDR_W  rs1 index of instruction in ID
id_rs1_used_i  input  1  instruction in ID reads rs1
id_rs2_i  input  REG_ADDR_W  rs2 index of instruction in ID
id_rs2_used_i  input  1  instruction in ID reads rs2
id_rd_i  input  REG_ADDR_W  rd index of instruction in ID
id_rd_we_i  input  1  instruction in ID writes rd
id_valid_i  input  1  ID holds a real (non-bubble) instruction
ex_br_taken_i  input  1  EX redirects PC this cycle (same signal as PC select)
stall_o  output  2  bit0 hold PC, bit1 hold IF/ID; 2'b11 on hazard, else 2'b00
flush_ifid_o  output  1  invalidate IF/ID on next edge
flush_idex_o  output  1  load bubble into ID/EX on next edge
stall_cnt_o  output  CNT_W  count of cycles with stall_o != 0

Behaviour:
- Reset is asynchronous, active-high, and may assert mid-operation. On assertion: all scoreboard entries invalid, stall_cnt_o = 0, and stall_o = 2'b00, flush_ifid_o = 0, flush_idex_o = 0 immediately, regardless of inputs.
- Scoreboard: sb[0] = EX, sb[1] = MEM, sb[2] = WB. Each entry is {valid, rd}.
- Every edge: sb[2] <= sb[1]; sb[1] <= sb[0]; sb[0] <= {id_valid_i && id_rd_we_i && id_rd_i != 0 && !hazard && !ex_br_taken_i, id_rd_i}.
- hazard (combinational) is true when id_valid_i and any of:
  - id_rs1_used_i, rs1 != 0, and rs1 matches a valid entry in the checked set;
  - id_rs2_used_i, rs2 != 0, and rs2 matches a valid entry in the checked set.
  - Checked set is sb[0..2] by default (register file not write-through).
- Outputs (combinational, zero latency from ID inputs and scoreboard state):
  - ex_br_taken_i = 1: stall_o = 2'b00, flush_ifid_o = 1, flush_idex_o = 1. Branch has priority, because the PC ignores its select while stalled.
  - else hazard: stall_o = 2'b11, flush_idex_o = 1 (bubble), flush_ifid_o = 0.
  - else all zero.
- Stall length: dependency on the immediately preceding instruction gives 3 stall cycles; on the instruction 2 back, 2 cycles; 3 back, 1 cycle; 4 or more back, 0.
- x0 is never a hazard, either as a source or as a destination.
- Branch in EX: the branch's own entry is already in sb[0] and is retained, so JAL/JALR rd is tracked. The squashed ID instruction is never inserted.
- stall_cnt_o increments on each edge where stall_o != 0 and saturates at all-ones; no wrap.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: the register file writes in the first half-cycle, so the checked set is sb[0..1] only. Max stall becomes 2 cycles (1-back: 2; 2-back: 1).
- Undefined: checked set is sb[0..2], as above.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef sb_entry_t {logic valid; logic [REG_ADDR_W-1:0] rd;};
  - localparam STALL_NONE = 2'b00, STALL_ALL = 2'b11;
  - localparam SB_DEPTH = 3.
- One sub-module: hazard_scoreboard (shift register plus match compare, outputs rs1_hit/rs2_hit). Output muxing and the counter stay in hazard_ctrl.

Test Plan:
- Back-to-back dependency: "addi x5,x0,1" then "add x6,x5,x5" -> stall_o=2'b11 and flush_idex_o=1 for exactly 3 cycles, then 2'b00; stall_cnt_o=3. With RF_BYPASS_EN: 2 cycles, stall_cnt_o=2.
- x0 and unused sources: producer writes x0, or consumer has rs2_used=0 and rs2 matches an in-flight rd -> stall_o stays 2'b00 every cycle.
- Distance 2: "addi x7", one independent instruction, then "sub x8,x7,x1" -> 2 stall cycles (1 with RF_BYPASS_EN).
- Branch vs hazard: ex_br_taken_i=1 in the same cycle ID has a pending hazard on x5 -> stall_o=2'b00, flush_ifid_o=1, flush_idex_o=1. Next cycle sb[0].valid=0 and the squashed rd is never tracked.
- Async reset mid-stall: assert rst_i between edges during cycle 2 of a 3-cycle stall -> stall_o=2'b00 and stall_cnt_o=0 before the next edge. After release, the same consumer in ID -> no stall.
- Counter saturation: CNT_W=4, force 20 consecutive hazard cycles -> stall_cnt_o holds 4'hF.
